imem_loader: RTL and testbench

Program loader that writes a byte stream into the processor's instruction memory through its write port. It accepts instructions one byte per handshake from an upstream source (testbench, UART or boot ROM), assigns consecutive addresses starting at `BASE_ADDR`, and issues one registered write per byte. It holds the CPU while loading and signals completion with a one-cycle `done` pulse. It sits between the program source and the instruction memory, ahead of instruction fetch.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/imem_loader.sv | 111 +++++++++++
 tb/tb_imem_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: instruction/address widths, default instruction
// memory depth and the program loader state encoding.
package cpu_pkg;

    localparam int INSTR_W    = 8;
    localparam int ADDR_W     = 8;
    localparam int IMEM_DEPTH = 25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_t;

    // A load request is legal only if it fits into the instruction memory.
    function automatic logic len_ok(input logic [7:0] len, input int depth);
        int len_int;
        len_int = int'({24'd0, len});
        return (len_int >= 1) && (len_int <= depth);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams bytes from an upstream source into instruction memory at consecutive
// addresses from BASE_ADDR, holding the CPU until the load completes.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int                DEPTH     = IMEM_DEPTH,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         len,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               busy,
    output logic               cpu_hold,
    output logic               done,
    output logic               err
);

    // Handshake: a byte moves when in_valid && in_ready at a rising edge;
    // in_ready depends only on the state, never on in_valid.

    load_state_t        state_q, state_d;
    logic [7:0]         count_q, count_d;
    logic [7:0]         len_q, len_d;
    logic               err_q, err_d;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [INSTR_W-1:0] wdata_q;
    logic               xfer;

    assign in_ready = (state_q == LOAD);
    assign xfer     = in_ready && in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= 8'd0;
            len_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok(len, DEPTH)) begin
                        len_d   = len;
                        count_d = 8'd0;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    count_d = count_q + 8'd1;
                    if ((count_q + 8'd1) == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address and data hold their last value between writes; only we pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= xfer;
            if (xfer) begin
                addr_q  <= BASE_ADDR + count_q;
                wdata_q <= in_data;
            end
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);
    assign cpu_hold  = busy;
    assign done      = (state_q == DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (BASE_ADDR 0 and 8'hFE) share stimulus;
// expected writes come from a list model of "byte i lands at base+i mod 256".
module tb_imem_loader;

    localparam int            DEPTH = 25;
    localparam logic [7:0]    BASE0 = 8'h00;
    localparam logic [7:0]    BASE1 = 8'hFE;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;

    logic       in_ready0, mem_we0, busy0, cpu_hold0, done0, err0;
    logic [7:0] mem_addr0, mem_wdata0;
    logic       in_ready1, mem_we1, busy1, cpu_hold1, done1, err1;
    logic [7:0] mem_addr1, mem_wdata1;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
        .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .busy(busy0), .cpu_hold(cpu_hold0), .done(done0), .err(err0)
    );

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .busy(busy1), .cpu_hold(cpu_hold1), .done(done1), .err(err1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp0_q[$];
    logic [15:0] exp1_q[$];
    logic [15:0] w0_q[$];
    logic [15:0] w1_q[$];
    logic [7:0]  data_buf[32];
    int done_cnt = 0;
    int done_at  = -1;
    int err_cnt  = 0;
    int busy_cnt = 0;

    // Observe outputs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we0) w0_q.push_back({mem_addr0, mem_wdata0});
            if (mem_we1) w1_q.push_back({mem_addr1, mem_wdata1});
            if (done0) begin
                done_cnt++;
                done_at = w0_q.size();
            end
            if (err0) err_cnt++;
            if (busy0) busy_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_obs();
        w0_q.delete();
        w1_q.delete();
        exp0_q.delete();
        exp1_q.delete();
        done_cnt = 0;
        done_at  = -1;
        err_cnt  = 0;
        busy_cnt = 0;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) data_buf[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic model_load(input int n);
        for (int i = 0; i < n; i++) begin
            exp0_q.push_back({8'((int'(BASE0) + i) % 256), data_buf[i]});
            exp1_q.push_back({8'((int'(BASE1) + i) % 256), data_buf[i]});
        end
    endtask

    task automatic start_load(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Sends n bytes from data_buf; gaps[i] inserts one idle cycle before byte i.
    // Returns #1 after the edge that accepted the last byte.
    task automatic send_stream(input int n, input logic [31:0] gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps[i]) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = data_buf[i];
            for (int t = 0; ; t++) begin
                logic ok;
                @(negedge clk);
                ok = in_ready0;
                @(posedge clk);
                #1;
                if (ok) break;
                if (t > 50) begin
                    chk("accept_timeout", 32'(t), 32'(0));
                    break;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int n);
        chk({tag, "_nwr0"}, 32'(w0_q.size()), 32'(n));
        chk({tag, "_nwr1"}, 32'(w1_q.size()), 32'(n));
        while (w0_q.size() > 0 && exp0_q.size() > 0)
            chk({tag, "_wr0"}, 32'(w0_q.pop_front()), 32'(exp0_q.pop_front()));
        while (w1_q.size() > 0 && exp1_q.size() > 0)
            chk({tag, "_wr1"}, 32'(w1_q.pop_front()), 32'(exp1_q.pop_front()));
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(1));
        chk({tag, "_done_with_last"}, 32'(done_at), 32'(n));
        chk({tag, "_idle_after"}, {31'd0, busy0}, 32'd0);
    endtask

    // Full load with model; caller chooses gap mask. Ends one cycle after DONE.
    task automatic run_load(input string tag, input int n, input logic [31:0] gaps);
        clear_obs();
        fill_random(n);
        model_load(n);
        start_load(8'(n));
        chk({tag, "_busy"}, {30'd0, busy0, cpu_hold0}, 32'd3);
        send_stream(n, gaps);
        @(posedge clk);
        #1;
        check_writes(tag, n);
    endtask

    task automatic reject_len(input string tag, input logic [7:0] l);
        clear_obs();
        start_load(l);
        chk({tag, "_err"}, {31'd0, err0}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy0}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_err_pulse"}, {31'd0, err0}, 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd1);
        chk({tag, "_no_write"}, 32'(w0_q.size() + w1_q.size()), 32'd0);
    endtask

    initial begin
        // Reset state.
        #2;
        chk("reset_outputs", {10'd0, in_ready0, mem_we0, mem_addr0, mem_wdata0,
                              busy0, cpu_hold0, done0, err0}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // len=3 back-to-back: consecutive writes, done with last, busy 4 cycles.
        clear_obs();
        data_buf[0] = 8'hA1;
        data_buf[1] = 8'hB2;
        data_buf[2] = 8'hC3;
        model_load(3);
        start_load(8'd3);
        send_stream(3, 32'd0);
        @(posedge clk);
        #1;
        chk("len3_busy_cycles", 32'(busy_cnt), 32'd4);
        check_writes("len3", 3);

        // len=4 with valid pattern 1,0,1,0,1,1.
        run_load("gapped", 4, 32'b0110);

        // Illegal lengths.
        reject_len("len0", 8'd0);
        reject_len("len26", 8'd26);
        reject_len("len255", 8'd255);

        // Maximum legal length.
        run_load("len_max", DEPTH, 32'd0);

        // Start during LOAD is ignored; start during DONE is ignored too.
        clear_obs();
        fill_random(4);
        model_load(4);
        start_load(8'd4);
        start_load(8'd2);
        send_stream(4, 32'd0);
        start_load(8'd1);
        chk("start_in_done_ignored", {31'd0, busy0}, 32'd0);
        check_writes("start_in_load", 4);
        chk("start_in_load_no_err", 32'(err_cnt), 32'd0);

        // Reset mid-load after 2 of 5 bytes, with the second write pending.
        clear_obs();
        fill_random(5);
        start_load(8'd5);
        send_stream(2, 32'd0);
        chk("pending_write", {31'd0, mem_we0}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_outputs0", {10'd0, in_ready0, mem_we0, mem_addr0, mem_wdata0,
                             busy0, cpu_hold0, done0, err0}, 32'd0);
        chk("rst_outputs1", {10'd0, in_ready1, mem_we1, mem_addr1, mem_wdata1,
                             busy1, cpu_hold1, done1, err1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_no_done", 32'(done_cnt), 32'd0);
        run_load("after_rst", 1, 32'd0);

        // Randomized loads and rejects.
        for (int k = 0; k < 8; k++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            run_load("rand", n, 32'($urandom) & 32'h01FF_FFFF);
            if ($urandom_range(0, 1) == 1)
                reject_len("rand_bad", 8'($urandom_range(DEPTH + 1, 255)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
